// File: rtl/updown_monitor.sv
// updown_monitor: watches an up/down BCD digit counter, locks onto its
// count direction, tracks a tens digit from wraps and flags illegal steps.
// Ports: clk, rst (sync, active high), in_en, number[3:0], zero ->
//   dir, dir_valid, tens[3:0], wrap_up, wrap_dn, step_err, zero_err.
// Optional: define UPDOWN_MONITOR_ZERO_CHECK_EN to check the zero flag.
module updown_monitor #(
  parameter int MAX_DIGIT = 9,
  parameter int LOCK_CNT  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_en,
  input  logic [3:0] number,
  input  logic       zero,
  output logic       dir,
  output logic       dir_valid,
  output logic [3:0] tens,
  output logic       wrap_up,
  output logic       wrap_dn,
  output logic       step_err,
  output logic       zero_err
);

  localparam logic [3:0] MAXD = 4'(MAX_DIGIT);
  localparam logic [2:0] LCNT = 3'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LOCK_UP,
    LOCK_DN
  } state_t;

  state_t     r_state, w_state;
  logic [3:0] r_prev, w_prev;
  logic [3:0] r_tens, w_tens;
  logic [2:0] r_cnt, w_cnt;
  logic       r_cand, w_cand;
  logic       r_dir, w_dir;
  logic       r_wu, w_wu;
  logic       r_wd, w_wd;
  logic       r_se, w_se;

  logic [4:0] w_exp_up;
  logic [3:0] w_exp_dn;
  logic       w_in_rng;
  logic       w_up;
  logic       w_dn;
  logic       w_ill;
  logic [2:0] w_sync_cnt;

  // exp_up is one bit wider so that an out-of-range prev of 15
  // expects 16 and can never alias onto digit 0.
  assign w_exp_up = (r_prev == MAXD) ? 5'd0
                  : {1'b0, r_prev} + 5'd1;
  assign w_exp_dn = (r_prev == 4'd0) ? MAXD
                  : r_prev - 4'd1;
  assign w_in_rng = (number <= MAXD);
  assign w_up  = w_in_rng && ({1'b0, number} == w_exp_up);
  assign w_dn  = w_in_rng && (number == w_exp_dn);
  assign w_ill = !(w_up || w_dn);

  // a step against the candidate direction restarts the run at 1
  assign w_sync_cnt = (w_up == r_cand) ? r_cnt + 3'd1 : 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_prev  <= 4'd0;
      r_tens  <= 4'd0;
      r_cnt   <= 3'd0;
      r_cand  <= 1'b0;
      r_dir   <= 1'b0;
      r_wu    <= 1'b0;
      r_wd    <= 1'b0;
      r_se    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_prev  <= w_prev;
      r_tens  <= w_tens;
      r_cnt   <= w_cnt;
      r_cand  <= w_cand;
      r_dir   <= w_dir;
      r_wu    <= w_wu;
      r_wd    <= w_wd;
      r_se    <= w_se;
    end
  end

  always_comb begin
    w_state = r_state;
    w_prev  = r_prev;
    w_tens  = r_tens;
    w_cnt   = r_cnt;
    w_cand  = r_cand;
    w_dir   = r_dir;
    w_wu    = 1'b0;
    w_wd    = 1'b0;
    w_se    = 1'b0;
    if (in_en) begin
      w_prev = number;
      unique case (r_state)
        IDLE: begin
          w_state = SYNC;
        end
        SYNC: begin
          if (w_ill) begin
            w_se  = 1'b1;
            w_cnt = 3'd0;
          end else begin
            w_cand = w_up;
            if (w_sync_cnt >= LCNT) begin
              w_state = w_up ? LOCK_UP : LOCK_DN;
              w_dir   = w_up;
              w_cnt   = 3'd0;
            end else begin
              w_cnt = w_sync_cnt;
            end
          end
        end
        LOCK_UP, LOCK_DN: begin
          unique case (1'b1)
            w_ill: begin
              w_se    = 1'b1;
              w_state = SYNC;
              w_cnt   = 3'd0;
            end
            w_up: begin
              w_state = LOCK_UP;
              w_dir   = 1'b1;
              if (r_prev == MAXD) begin
                w_wu   = 1'b1;
                w_tens = (r_tens == 4'd9) ? 4'd0
                       : r_tens + 4'd1;
              end
            end
            w_dn: begin
              w_state = LOCK_DN;
              w_dir   = 1'b0;
              if (r_prev == 4'd0) begin
                w_wd   = 1'b1;
                w_tens = (r_tens == 4'd0) ? 4'd9
                       : r_tens - 4'd1;
              end
            end
            default: ;
          endcase
        end
        default: begin
          w_state = IDLE;
        end
      endcase
    end
  end

`ifdef UPDOWN_MONITOR_ZERO_CHECK_EN
  logic r_ze;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ze <= 1'b0;
    end else begin
      r_ze <= in_en && (zero != (number == 4'd0));
    end
  end

  assign zero_err = r_ze;
`else
  logic w_unused_zero;

  assign w_unused_zero = zero;
  assign zero_err      = 1'b0;
`endif

  assign dir       = r_dir;
  assign dir_valid = (r_state == LOCK_UP)
                  || (r_state == LOCK_DN);
  assign tens      = r_tens;
  assign wrap_up   = r_wu;
  assign wrap_dn   = r_wd;
  assign step_err  = r_se;

endmodule

// File: tb/tb_updown_monitor.sv
// tb_updown_monitor: directed table, corner sequences and a random
// run against a behavioural model of the up/down monitor.
module tb_updown_monitor;

  localparam int MAXV = 9;
  localparam int LOCKV = 2;
`ifdef UPDOWN_MONITOR_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_en;
  logic [3:0] number;
  logic       zero;
  logic       dir;
  logic       dir_valid;
  logic [3:0] tens;
  logic       wrap_up;
  logic       wrap_dn;
  logic       step_err;
  logic       zero_err;

  updown_monitor #(
    .MAX_DIGIT(MAXV),
    .LOCK_CNT (LOCKV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_en    (in_en),
    .number   (number),
    .zero     (zero),
    .dir      (dir),
    .dir_valid(dir_valid),
    .tens     (tens),
    .wrap_up  (wrap_up),
    .wrap_dn  (wrap_dn),
    .step_err (step_err),
    .zero_err (zero_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // behavioural model: phase 0=waiting for first sample,
  // 1=searching for a direction run, 2=locked
  int m_phase, m_prev, m_run, m_tens;
  bit m_cand, m_dir;
  bit e_wu, e_wd, e_se, e_ze;

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model(bit r, bit en, int num, bit z);
    int up_n, dn_n, kind;
    e_wu = 0; e_wd = 0; e_se = 0; e_ze = 0;
    if (r) begin
      m_phase = 0; m_prev = 0; m_run = 0;
      m_tens = 0; m_dir = 0; m_cand = 0;
      return;
    end
    if (!en) return;
    e_ze = ZC && (z != (num == 0));
    if (m_phase == 0) begin
      m_phase = 1;
    end else begin
      up_n = (m_prev == MAXV) ? 0 : m_prev + 1;
      dn_n = (m_prev == 0) ? MAXV : m_prev - 1;
      kind = 0;
      if (num <= MAXV && num == up_n) kind = 1;
      else if (num <= MAXV && num == dn_n) kind = -1;
      if (m_phase == 2) begin
        if (kind == 0) begin
          e_se = 1; m_phase = 1; m_run = 0;
        end else if (kind > 0) begin
          m_dir = 1;
          if (m_prev == MAXV) begin
            m_tens = (m_tens + 1) % 10; e_wu = 1;
          end
        end else begin
          m_dir = 0;
          if (m_prev == 0) begin
            m_tens = (m_tens + 9) % 10; e_wd = 1;
          end
        end
      end else begin
        if (kind == 0) begin
          e_se = 1; m_run = 0;
        end else begin
          if (m_run > 0 && m_cand == (kind > 0)) m_run++;
          else begin
            m_cand = (kind > 0); m_run = 1;
          end
          if (m_run >= LOCKV) begin
            m_phase = 2; m_dir = m_cand; m_run = 0;
          end
        end
      end
    end
    m_prev = num;
  endtask

  task automatic step(bit r, bit en, int num, bit z);
    rst = r; in_en = en; number = 4'(num); zero = z;
    @(posedge clk);
    #1;
    model(r, en, num, z);
  endtask

  task automatic chk_model(string t);
    bit dv;
    dv = (m_phase == 2);
    chk({t, "_dv"}, 8'(dir_valid), 8'(dv));
    if (dv) chk({t, "_dir"}, 8'(dir), 8'(m_dir));
    chk({t, "_tens"}, 8'(tens), 8'(m_tens));
    chk({t, "_wu"}, 8'(wrap_up), 8'(e_wu));
    chk({t, "_wd"}, 8'(wrap_dn), 8'(e_wd));
    chk({t, "_se"}, 8'(step_err), 8'(e_se));
    chk({t, "_ze"}, 8'(zero_err), 8'(e_ze));
  endtask

  typedef struct {
    bit en; int num;
    bit dv; bit dr; int tn;
    bit wu; bit wd; bit se;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int p, sel, num, n_se, n;
    bit en, z, r;
    rst = 1; in_en = 0; number = 0; zero = 0;

    tbl[0]  = '{1, 3, 0,0,0, 0,0,0};
    tbl[1]  = '{1, 4, 0,0,0, 0,0,0};
    tbl[2]  = '{1, 5, 1,1,0, 0,0,0};
    tbl[3]  = '{1, 6, 1,1,0, 0,0,0};
    tbl[4]  = '{1, 7, 1,1,0, 0,0,0};
    tbl[5]  = '{1, 8, 1,1,0, 0,0,0};
    tbl[6]  = '{1, 9, 1,1,0, 0,0,0};
    tbl[7]  = '{1, 0, 1,1,1, 1,0,0};
    tbl[8]  = '{1, 1, 1,1,1, 0,0,0};
    tbl[9]  = '{1, 0, 1,0,1, 0,0,0};
    tbl[10] = '{1, 9, 1,0,0, 0,1,0};
    tbl[11] = '{0, 9, 1,0,0, 0,0,0};
    tbl[12] = '{1, 8, 1,0,0, 0,0,0};
    tbl[13] = '{1, 8, 0,0,0, 0,0,1};
    tbl[14] = '{0, 0, 0,0,0, 0,0,0};
    tbl[15] = '{1,12, 0,0,0, 0,0,1};
    tbl[16] = '{1, 6, 0,0,0, 0,0,1};
    tbl[17] = '{1, 7, 0,0,0, 0,0,0};
    tbl[18] = '{1, 8, 1,1,0, 0,0,0};

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_dv", 8'(dir_valid), 8'd0);
    chk("rst_dir", 8'(dir), 8'd0);
    chk("rst_tens", 8'(tens), 8'd0);
    chk("rst_pulses",
        8'({wrap_up, wrap_dn, step_err, zero_err}), 8'd0);

    foreach (tbl[i]) begin
      step(0, tbl[i].en, tbl[i].num, tbl[i].num == 0);
      chk($sformatf("tbl%0d_dv", i), 8'(dir_valid), 8'(tbl[i].dv));
      if (tbl[i].dv)
        chk($sformatf("tbl%0d_dir", i), 8'(dir), 8'(tbl[i].dr));
      chk($sformatf("tbl%0d_tens", i), 8'(tens), 8'(tbl[i].tn));
      chk($sformatf("tbl%0d_wu", i), 8'(wrap_up), 8'(tbl[i].wu));
      chk($sformatf("tbl%0d_wd", i), 8'(wrap_dn), 8'(tbl[i].wd));
      chk($sformatf("tbl%0d_se", i), 8'(step_err), 8'(tbl[i].se));
      chk($sformatf("tbl%0d_ze", i), 8'(zero_err), 8'd0);
    end

    // long up run: tens must roll 9->0 without any step error
    step(1, 0, 0, 0);
    n_se = 0;
    for (int i = 0; i <= 110; i++) begin
      step(0, 1, i % 10, (i % 10) == 0);
      chk_model("up100");
      if (step_err) n_se++;
      if (i == 100) begin
        chk("up100_tens_roll", 8'(tens), 8'd0);
        chk("up100_wrap", 8'(wrap_up), 8'd1);
      end
    end
    chk("up100_no_err", 8'(n_se), 8'd0);
    chk("up100_final_tens", 8'(tens), 8'd1);

    // reset while locked with a nonzero tens
    step(1, 1, 2, 0);
    chk("midrst_dv", 8'(dir_valid), 8'd0);
    chk("midrst_dir", 8'(dir), 8'd0);
    chk("midrst_tens", 8'(tens), 8'd0);
    chk("midrst_pulses",
        8'({wrap_up, wrap_dn, step_err, zero_err}), 8'd0);

    // down wrap from tens 0 to 9
    step(0, 1, 3, 0);
    step(0, 1, 2, 0);
    step(0, 1, 1, 0);
    chk("dn_lock", 8'(dir_valid), 8'd1);
    chk("dn_dir", 8'(dir), 8'd0);
    step(0, 1, 0, 1);
    step(0, 1, 9, 0);
    chk("dn_wrap", 8'(wrap_dn), 8'd1);
    chk("dn_tens9", 8'(tens), 8'd9);

    // zero flag checking
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("ze_0_0", 8'(zero_err), 8'(ZC));
    step(0, 1, 3, 1);
    chk("ze_3_1", 8'(zero_err), 8'(ZC));
    chk("ze_3_1_se", 8'(step_err), 8'd1);
    step(0, 1, 0, 1);
    chk("ze_0_1", 8'(zero_err), 8'd0);
    step(0, 0, 5, 1);
    chk("ze_gap", 8'(zero_err), 8'd0);

    // random run against the model
    step(1, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 1500; i++) begin
      p = m_prev;
      sel = $urandom_range(0, 9);
      if (sel < 4) num = (p == MAXV) ? 0 : (p + 1) % 16;
      else if (sel < 7) num = (p == 0) ? MAXV : p - 1;
      else if (sel == 7) num = p;
      else num = $urandom_range(0, 15);
      en = ($urandom_range(0, 3) != 0);
      z = (num == 0);
      if ($urandom_range(0, 7) == 0) z = !z;
      r = ($urandom_range(0, 149) == 0);
      step(r, en, num, z);
      chk_model("rand");
      n++;
    end
    chk("rand_count", 8'(n / 10), 8'd150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_monitor.md
Name: updown_monitor

Overview:
- Receiving end of the up/down BCD digit counter interface.
- Samples the counter's registered digit and zero flag, infers count direction and locks onto it, then extends the count with a tracked tens digit using wrap detection.
- Flags any illegal step; sits beside the counter for self-check and display of a two-digit value.

Parameters:
MAX_DIGIT, 9, top count value of the observed counter; legal range 2..15 (the counter wraps MAX_DIGIT<->0).
LOCK_CNT, 2, consecutive same-direction legal steps required to lock; legal range 1..7.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_en  input  1  sample strobe; number/zero valid this cycle
number  input  4  observed counter digit
zero  input  1  observed zero flag (1 when digit was 0)
dir  output  1  1=counting up, 0=counting down; valid only when dir_valid=1
dir_valid  output  1  1 while locked
tens  output  4  tracked tens digit, BCD 0..9
wrap_up  output  1  one-cycle pulse on locked up-wrap MAX_DIGIT->0
wrap_dn  output  1  one-cycle pulse on locked down-wrap 0->MAX_DIGIT
step_err  output  1  one-cycle pulse on illegal step
zero_err  output  1  one-cycle pulse on zero-flag mismatch (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge, highest priority, including mid-operation):
  - state=IDLE, prev=0, lock_cnt=0.
  - Outputs: dir=0, dir_valid=0, tens=0, all pulses 0.
- All outputs are registered. Response appears one clk after the sampled cycle.
- in_en=0:
  - State, prev, tens, dir and dir_valid hold.
  - All pulse outputs are 0.
- Step classification (when in_en=1 and state != IDLE):
  - exp_up = (prev==MAX_DIGIT) ? 0 : prev+1.
  - exp_dn = (prev==0) ? MAX_DIGIT : prev-1.
  - UP if number==exp_up; DN if number==exp_dn; ILL otherwise.
  - ILL includes number==prev (the counter never holds) and number>MAX_DIGIT.
- prev <= number on every in_en=1 sample, including ILL samples.
- States: IDLE, SYNC, LOCK_UP, LOCK_DN.
- IDLE:
  - First in_en sample: store prev, go to SYNC.
  - No step_err and no step classification on this sample.
- SYNC:
  - UP/DN same as last candidate direction: lock_cnt+1. Otherwise set candidate direction and lock_cnt=1.
  - When lock_cnt reaches LOCK_CNT: enter LOCK_UP or LOCK_DN; dir_valid=1; dir=candidate.
  - The locking step itself does not change tens.
  - ILL: step_err pulse, lock_cnt=0, stay in SYNC.
- LOCK_UP / LOCK_DN:
  - UP: go to/stay in LOCK_UP, dir=1. If prev==MAX_DIGIT: tens=(tens==9)?0:tens+1 and wrap_up pulse.
  - DN: go to/stay in LOCK_DN, dir=0. If prev==0: tens=(tens==0)?9:tens-1 and wrap_dn pulse.
  - Direction reversal needs no relock, since the counter mode may change any cycle.
  - ILL: step_err pulse, go to SYNC, dir_valid=0, lock_cnt=0. tens holds its value (not cleared).
- tens is modified only in lock states. Reset is the only way to clear it.
- At most one of wrap_up, wrap_dn, step_err is asserted per cycle.

Optional Feature:
- Macro: UPDOWN_MONITOR_ZERO_CHECK_EN.
- Defined:
  - On every in_en=1 sample (any state, including IDLE), zero_err pulses next cycle if zero != (number==0).
  - zero_err is independent of, and may coincide with, step_err.
- Undefined:
  - zero input is ignored.
  - zero_err is tied to 0.

Test Plan:
- Reset then in_en=1 with number 3,4,5,6 (LOCK_CNT=2) -> dir_valid=1, dir=1 one clk after the sample of 5; tens=0; no pulses.
- Locked up: 8,9,0,1 -> wrap_up pulse exactly one clk after the 0 sample; tens=1. Run 100 up steps from 0 -> tens wraps 9->0 with no step_err.
- Locked up at 2, then 1,0,9 -> dir=0 one clk after the 1 sample with dir_valid held at 1; wrap_dn on the 9 sample; tens decrements (0->9 if tens was 0).
- Locked, then 5 followed by 5 (hold) or by 12 -> step_err one-cycle pulse; dir_valid=0; tens unchanged. Then 13? no: 6,7 -> relock.
- in_en toggled 0 between samples 4,(gap),5 -> state preserved, no pulses in gap. rst=1 asserted mid-lock -> next cycle all outputs 0, state IDLE.
- With UPDOWN_MONITOR_ZERO_CHECK_EN: number=0, zero=0 -> zero_err=1; number=3, zero=1 -> zero_err=1; number=0, zero=1 -> zero_err=0. Without the macro: zero_err stays 0 for all cases.
